// File: rtl/match_control.sv
// Two-fighter match sequencer: countdown, live play with hit/shield/immunity
// handling, round-end hold, and best-of-N match resolution.
//
// state   | meaning
// START   | idle, waiting for a select press to begin a match
// COUNT   | pre-round countdown, hits ignored
// PLAY    | round live, hits evaluated
// RND_END | round-end hold, then decide next round or match result
// WIN     | match won by player, counters frozen until select
// LOSE    | match lost by player, counters frozen until select
module match_control #(
    parameter int MAX_HP        = 3,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5,
    parameter int INVULN_CYCLES = 4,
    parameter int COUNT_CYCLES  = 8,
    parameter int END_CYCLES    = 4,
    localparam int HP_W = $clog2(MAX_HP + 1),
    localparam int RW   = $clog2(MAX_ROUNDS + 1),
    localparam int CMAX = (COUNT_CYCLES > END_CYCLES) ? COUNT_CYCLES : END_CYCLES,
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            select,
    input  logic            player_hit,
    input  logic            enemy_hit,
    input  logic            player_shield,
    input  logic            enemy_shield,
    output logic [2:0]      o_state,
    output logic            o_is_gaming,
    output logic [HP_W-1:0] o_player_hp,
    output logic [HP_W-1:0] o_enemy_hp,
    output logic [RW-1:0]   o_player_rounds,
    output logic [RW-1:0]   o_enemy_rounds,
    output logic [RW-1:0]   o_round_num,
    output logic [CW-1:0]   o_timer,
    output logic            o_player_invuln,
    output logic            o_enemy_invuln
);

    localparam int IW = $clog2(INVULN_CYCLES + 1);

    localparam logic [HP_W-1:0] HP_FULL   = HP_W'(MAX_HP);
    localparam logic [RW-1:0]   RND_GOAL  = RW'(ROUNDS_TO_WIN);
    localparam logic [RW-1:0]   RND_LIMIT = RW'(MAX_ROUNDS);
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(COUNT_CYCLES - 1);
    localparam logic [CW-1:0]   END_LOAD  = CW'(END_CYCLES - 1);
    localparam logic [IW-1:0]   INV_LOAD  = IW'(INVULN_CYCLES);

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_COUNT   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_RND_END = 3'd3,
        ST_WIN     = 3'd4,
        ST_LOSE    = 3'd5
    } state_t;

    state_t          state_q;
    logic            select_q;
    logic [HP_W-1:0] php_q, ehp_q;
    logic [RW-1:0]   prnd_q, ernd_q, rnum_q;
    logic [CW-1:0]   timer_q;
    logic [IW-1:0]   pinv_q, einv_q;

    logic sel_rise;
    logic p_accept, e_accept;

    assign sel_rise = select & ~select_q;
    assign p_accept = player_hit & ~player_shield & (pinv_q == '0) & (php_q != '0);
    assign e_accept = enemy_hit  & ~enemy_shield  & (einv_q == '0) & (ehp_q != '0);

    // Match sequencer: all state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_START;
            select_q <= 1'b0;
            php_q    <= HP_FULL;
            ehp_q    <= HP_FULL;
            prnd_q   <= '0;
            ernd_q   <= '0;
            rnum_q   <= '0;
            timer_q  <= '0;
            pinv_q   <= '0;
            einv_q   <= '0;
        end else begin
            select_q <= select;
            case (state_q)
                ST_START: begin
                    if (sel_rise) begin
                        state_q <= ST_COUNT;
                        prnd_q  <= '0;
                        ernd_q  <= '0;
                        rnum_q  <= '0;
                        php_q   <= HP_FULL;
                        ehp_q   <= HP_FULL;
                        timer_q <= CNT_LOAD;
                    end
                end
                ST_COUNT: begin
                    if (timer_q == '0) begin
                        state_q <= ST_PLAY;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ST_PLAY: begin
                    if ((php_q == '0) || (ehp_q == '0)) begin
                        // A double knockout is a draw: nobody is awarded.
                        if ((ehp_q == '0) && (php_q != '0) && (prnd_q != RND_GOAL)) begin
                            prnd_q <= prnd_q + 1'b1;
                        end
                        if ((php_q == '0) && (ehp_q != '0) && (ernd_q != RND_GOAL)) begin
                            ernd_q <= ernd_q + 1'b1;
                        end
                        if (rnum_q != RND_LIMIT) begin
                            rnum_q <= rnum_q + 1'b1;
                        end
                        state_q <= ST_RND_END;
                        timer_q <= END_LOAD;
                        pinv_q  <= '0;
                        einv_q  <= '0;
                    end else begin
                        if (p_accept) begin
                            php_q  <= php_q - 1'b1;
                            pinv_q <= INV_LOAD;
                        end else if (pinv_q != '0) begin
                            pinv_q <= pinv_q - 1'b1;
                        end
                        if (e_accept) begin
                            ehp_q  <= ehp_q - 1'b1;
                            einv_q <= INV_LOAD;
                        end else if (einv_q != '0) begin
                            einv_q <= einv_q - 1'b1;
                        end
                    end
                end
                ST_RND_END: begin
                    if (timer_q == '0) begin
                        if (prnd_q == RND_GOAL) begin
                            state_q <= ST_WIN;
                        end else if (ernd_q == RND_GOAL) begin
                            state_q <= ST_LOSE;
                        end else if (rnum_q == RND_LIMIT) begin
                            // Tied round count at the limit goes to the enemy.
                            state_q <= (prnd_q > ernd_q) ? ST_WIN : ST_LOSE;
                        end else begin
                            state_q <= ST_COUNT;
                            php_q   <= HP_FULL;
                            ehp_q   <= HP_FULL;
                            timer_q <= CNT_LOAD;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (sel_rise) begin
                        state_q <= ST_START;
                    end
                end
                default: state_q <= ST_START;
            endcase
        end
    end

    assign o_state         = state_q;
    assign o_is_gaming     = (state_q == ST_PLAY);
    assign o_player_hp     = php_q;
    assign o_enemy_hp      = ehp_q;
    assign o_player_rounds = prnd_q;
    assign o_enemy_rounds  = ernd_q;
    assign o_round_num     = rnum_q;
    assign o_timer         = timer_q;
    assign o_player_invuln = (pinv_q != '0);
    assign o_enemy_invuln  = (einv_q != '0);

endmodule

// File: tb/tb_match_control.sv
// Directed bench for match_control with default parameters.
module tb_match_control;

    localparam int S_START = 0, S_COUNT = 1, S_PLAY = 2, S_RND_END = 3, S_WIN = 4, S_LOSE = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       select;
    logic       player_hit, enemy_hit, player_shield, enemy_shield;
    logic [2:0] o_state;
    logic       o_is_gaming;
    logic [1:0] o_player_hp, o_enemy_hp;
    logic [2:0] o_player_rounds, o_enemy_rounds, o_round_num;
    logic [2:0] o_timer;
    logic       o_player_invuln, o_enemy_invuln;

    int total = 0;
    int bad   = 0;

    match_control dut (
        .clk            (clk),
        .rst            (rst),
        .select         (select),
        .player_hit     (player_hit),
        .enemy_hit      (enemy_hit),
        .player_shield  (player_shield),
        .enemy_shield   (enemy_shield),
        .o_state        (o_state),
        .o_is_gaming    (o_is_gaming),
        .o_player_hp    (o_player_hp),
        .o_enemy_hp     (o_enemy_hp),
        .o_player_rounds(o_player_rounds),
        .o_enemy_rounds (o_enemy_rounds),
        .o_round_num    (o_round_num),
        .o_timer        (o_timer),
        .o_player_invuln(o_player_invuln),
        .o_enemy_invuln (o_enemy_invuln)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (int'(o_state) == target) break;
            step();
        end
        chk(tag, int'(o_state), target);
    endtask

    // kind: 0 player wins, 1 enemy wins, 2 draw
    task automatic play_round(input int kind);
        enemy_hit  = (kind != 1);
        player_hit = (kind != 0);
        repeat (11) step();
        enemy_hit  = 1'b0;
        player_hit = 1'b0;
        chk("ko_enemy_hp",  int'(o_enemy_hp),  (kind != 1) ? 0 : 3);
        chk("ko_player_hp", int'(o_player_hp), (kind != 0) ? 0 : 3);
        step();
        chk("ko_rnd_end", int'(o_state), S_RND_END);
    endtask

    initial begin
        int hp_m, inv_m;
        rst = 1'b1; select = 1'b0;
        player_hit = 1'b0; enemy_hit = 1'b0; player_shield = 1'b0; enemy_shield = 1'b0;
        step(); step();
        chk("rst_state",  int'(o_state), S_START);
        chk("rst_php",    int'(o_player_hp), 3);
        chk("rst_ehp",    int'(o_enemy_hp), 3);
        chk("rst_rounds", int'({o_player_rounds, o_enemy_rounds, o_round_num}), 0);
        chk("rst_timer",  int'(o_timer), 0);
        chk("rst_inv",    int'({o_player_invuln, o_enemy_invuln}), 0);
        chk("rst_gaming", int'(o_is_gaming), 0);
        rst = 1'b0;
        step();

        // Countdown 7..0 then PLAY on the 8th edge after the press.
        select = 1'b1;
        step();
        select = 1'b0;
        chk("cnt_state", int'(o_state), S_COUNT);
        chk("cnt_t7", int'(o_timer), 7);
        for (int t = 6; t >= 0; t--) begin
            enemy_hit = 1'b1;
            step();
            chk("cnt_timer", int'(o_timer), t);
            chk("cnt_hold", int'(o_state), S_COUNT);
        end
        enemy_hit = 1'b0;
        step();
        chk("play_state", int'(o_state), S_PLAY);
        chk("play_gaming", int'(o_is_gaming), 1);
        chk("play_timer", int'(o_timer), 0);
        chk("play_ehp", int'(o_enemy_hp), 3);
        chk("play_php", int'(o_player_hp), 3);

        // Shielded hits are rejected.
        enemy_hit = 1'b1; enemy_shield = 1'b1;
        repeat (3) step();
        chk("shield_hp", int'(o_enemy_hp), 3);
        chk("shield_inv", int'(o_enemy_invuln), 0);
        enemy_shield = 1'b0;

        // Held hit: accepted at cycles 1 and 6 with immunity in between.
        hp_m = 3; inv_m = 0;
        for (int k = 1; k <= 10; k++) begin
            if (inv_m == 0 && hp_m != 0) begin
                hp_m--; inv_m = 4;
            end else if (inv_m != 0) begin
                inv_m--;
            end
            if (k == 10) enemy_hit = 1'b0;
            step();
            chk("held_ehp", int'(o_enemy_hp), hp_m);
            chk("held_einv", int'(o_enemy_invuln), (inv_m != 0) ? 1 : 0);
        end
        enemy_hit = 1'b0;

        // Bring player to 1, then simultaneous hits -> draw.
        player_hit = 1'b1;
        repeat (6) step();
        player_hit = 1'b0;
        chk("p_hp1", int'(o_player_hp), 1);
        chk("p_inv", int'(o_player_invuln), 1);
        repeat (4) step();
        chk("p_inv_clear", int'(o_player_invuln), 0);
        player_hit = 1'b1; enemy_hit = 1'b1;
        step();
        player_hit = 1'b0; enemy_hit = 1'b0;
        chk("draw_hp", int'({o_player_hp, o_enemy_hp}), 0);
        chk("draw_still_play", int'(o_state), S_PLAY);
        step();
        chk("draw_state", int'(o_state), S_RND_END);
        chk("draw_rnum", int'(o_round_num), 1);
        chk("draw_rounds", int'({o_player_rounds, o_enemy_rounds}), 0);
        chk("draw_timer", int'(o_timer), 3);
        chk("draw_inv", int'({o_player_invuln, o_enemy_invuln}), 0);

        wait_state(S_COUNT, 10, "r2_count");
        chk("r2_timer", int'(o_timer), 7);
        chk("r2_hp", int'({o_player_hp, o_enemy_hp}), 15);
        select = 1'b1;
        step();
        select = 1'b0;
        chk("sel_ignored_count", int'(o_state), S_COUNT);

        // Player takes two rounds -> WIN.
        wait_state(S_PLAY, 20, "r2_play");
        play_round(0);
        chk("r2_prnd", int'(o_player_rounds), 1);
        chk("r2_rnum", int'(o_round_num), 2);
        wait_state(S_COUNT, 10, "r3_count");
        wait_state(S_PLAY, 20, "r3_play");
        play_round(0);
        repeat (3) step();
        chk("r3_hold", int'(o_state), S_RND_END);
        chk("r3_t0", int'(o_timer), 0);
        step();
        chk("win_state", int'(o_state), S_WIN);
        chk("win_timer", int'(o_timer), 0);
        repeat (2) step();
        chk("win_hold", int'(o_state), S_WIN);
        chk("win_prnd", int'(o_player_rounds), 2);
        chk("win_rnum", int'(o_round_num), 3);

        select = 1'b1;
        step();
        chk("to_start", int'(o_state), S_START);
        repeat (2) step();
        chk("held_sel_start", int'(o_state), S_START);
        chk("start_hold_prnd", int'(o_player_rounds), 2);
        select = 1'b0;
        step();
        select = 1'b1;
        step();
        select = 1'b0;
        chk("m2_count", int'(o_state), S_COUNT);
        chk("m2_clear", int'({o_player_rounds, o_enemy_rounds, o_round_num}), 0);

        // Match 2: 1 win each, three draws -> LOSE on tie.
        wait_state(S_PLAY, 20, "m2_r1_play");
        play_round(0);
        wait_state(S_COUNT, 10, "m2_r2_count");
        wait_state(S_PLAY, 20, "m2_r2_play");
        play_round(1);
        chk("m2_ernd", int'(o_enemy_rounds), 1);
        for (int r = 0; r < 3; r++) begin
            wait_state(S_COUNT, 10, "m2_d_count");
            wait_state(S_PLAY, 20, "m2_d_play");
            play_round(2);
        end
        chk("m2_rnum", int'(o_round_num), 5);
        chk("m2_rounds", int'({o_player_rounds, o_enemy_rounds}), 9);
        wait_state(S_LOSE, 10, "m2_lose");

        // Async reset aborts a live round.
        select = 1'b1;
        step();
        select = 1'b0;
        step();
        select = 1'b1;
        step();
        select = 1'b0;
        wait_state(S_PLAY, 20, "m3_play");
        enemy_hit = 1'b1;
        step();
        enemy_hit = 1'b0;
        chk("m3_ehp", int'(o_enemy_hp), 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", int'(o_state), S_START);
        chk("arst_hp", int'({o_player_hp, o_enemy_hp}), 15);
        chk("arst_inv", int'(o_enemy_invuln), 0);
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/match_control.md
MATCH_CONTROL -- requirements
Module: match_control

Interface
REQ-001 SHALL have parameter MAX_HP, 3: hit points per fighter at round start (1..15).
REQ-002 SHALL have parameter ROUNDS_TO_WIN, 2: round wins needed to take the match.
REQ-003 SHALL have parameter MAX_ROUNDS, 5: round limit, including drawn rounds.
REQ-004 SHALL have parameter INVULN_CYCLES, 4: post-hit immunity window in cycles (>=1).
REQ-005 SHALL have parameter COUNT_CYCLES, 8: pre-round countdown length in cycles (>=1).
REQ-006 SHALL have parameter END_CYCLES, 4: round-end hold length in cycles (>=1).
REQ-007 SHALL derive HP_W=$clog2(MAX_HP+1), RW=$clog2(MAX_ROUNDS+1) and CW=$clog2(max(COUNT_CYCLES,END_CYCLES)).
REQ-008 SHALL have clk, input, 1: single clock; all state updates on the rising edge.
REQ-009 SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-010 SHALL have select, input, 1: level input; only its synchronous rising edge (sel_rise = select & ~select_q) is used.
REQ-011 SHALL have player_hit/enemy_hit, inputs, 1 each: a bullet contacts that fighter this cycle.
REQ-012 SHALL have player_shield/enemy_shield, inputs, 1 each: that fighter is defending.
REQ-013 SHALL have o_state, output, 3: START=0, COUNT=1, PLAY=2, RND_END=3, WIN=4, LOSE=5.
REQ-014 SHALL have o_is_gaming, output, 1: high iff o_state==PLAY.
REQ-015 SHALL have o_player_hp/o_enemy_hp, outputs, HP_W each: current hit points.
REQ-016 SHALL have o_player_rounds/o_enemy_rounds/o_round_num, outputs, RW each: round wins per fighter and rounds played.
REQ-017 SHALL have o_timer, output, CW: remaining COUNT or RND_END cycles, 0 in all other states.
REQ-018 SHALL have o_player_invuln/o_enemy_invuln, outputs, 1 each: that fighter's immunity counter is non-zero.

Function
REQ-019 START: on sel_rise, SHALL go to COUNT; clear rounds and round_num; load both HP with MAX_HP; load timer with COUNT_CYCLES-1.
REQ-020 COUNT: timer SHALL decrement once per cycle; the cycle after the timer reads 0, state SHALL be PLAY; hits SHALL be ignored.
REQ-021 PLAY: a hit SHALL be accepted iff hit & ~shield & immunity counter==0 & HP!=0; an accepted hit decrements HP by 1 and loads the immunity counter with INVULN_CYCLES on the next edge.
REQ-022 A non-zero immunity counter SHALL decrement by 1 each PLAY cycle and SHALL be cleared on leaving PLAY.
REQ-023 Player and enemy hits in the same cycle SHALL be evaluated independently; both may be accepted.
REQ-024 PLAY SHALL exit on the cycle after any registered HP reads 0: enemy HP 0 only -> player round +1; player HP 0 only -> enemy round +1; both 0 -> draw, no award.
REQ-025 On PLAY exit, state SHALL go to RND_END; round_num SHALL increment; timer SHALL load END_CYCLES-1.
REQ-026 RND_END: when the timer reads 0, evaluated in order: player_rounds==ROUNDS_TO_WIN -> WIN; enemy_rounds==ROUNDS_TO_WIN -> LOSE; round_num==MAX_ROUNDS -> WIN if player_rounds>enemy_rounds, else LOSE (ties lose); otherwise -> COUNT with HP reloaded and timer=COUNT_CYCLES-1.
REQ-027 WIN/LOSE: on sel_rise, SHALL go to START; all counters SHALL hold until then.
REQ-028 sel_rise SHALL be ignored in COUNT, PLAY and RND_END; a held select SHALL NOT retrigger.
REQ-029 HP and round counters SHALL never underflow or exceed their limits.

Reset
REQ-030 While rst=1: state=START, HP=MAX_HP both, rounds=0, round_num=0, timer=0, immunity=0, select_q=0; asserting rst mid-round SHALL abort immediately.

Verification (defaults)
REQ-031 Pulse select in START -> COUNT with timer 7..0, PLAY 8 cycles after the sel_rise edge; HP 3/3.
REQ-032 Hold enemy_hit 10 PLAY cycles -> enemy HP 3->2 at cycle 1, ->1 at cycle 6; o_enemy_invuln high between accepted hits.
REQ-033 enemy_hit with enemy_shield=1 -> HP unchanged, immunity stays 0.
REQ-034 Both fighters at HP 1, hit together -> both 0, RND_END, round_num=1, rounds 0/0 (draw).
REQ-035 Player wins two rounds -> WIN after the second RND_END hold; then select -> START; held select gives no second transition.
REQ-036 Five rounds: player wins 1, enemy wins 1, three draws -> LOSE (1:1 tie); rst asserted mid-PLAY -> START with HP 3/3 in the same cycle.
